corevx_ptw: RTL and testbench

- Sv32 hardware page table walker; fill side of corevx_tlb.
- On a TLB miss the cache/MMU control requests a walk for a 20-bit VPN.
- The walker reads up to two PTEs over a pipelined read-only memory port and returns the leaf PPN and access bits.
- The requester writes the returned phys/accesstag pair into the TLB using its write command.

---
 rtl/corevx_ptw_pkg.sv | 16 +
 rtl/corevx_ptw_pte_check.sv | 19 +
 rtl/corevx_ptw.sv | 89 ++++++++
 tb/tb_corevx_ptw.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_ptw_pkg.sv
// corevx_ptw_pkg: Sv32 PTE field positions, walker states and address helper.
package corevx_ptw_pkg;
    typedef enum int {
        PTE_V = 0, PTE_R = 1, PTE_W = 2, PTE_X = 3,
        PTE_U = 4, PTE_G = 5, PTE_A = 6, PTE_D = 7
    } pte_bit_t;

    localparam int PPN1_LSB = 20;
    localparam int PPN0_LSB = 10;

    typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, DONE} state_t;

    function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
        return {ppn, 12'b0} + {22'b0, idx, 2'b00};
    endfunction
endpackage

// File: rtl/corevx_ptw_pte_check.sv
// corevx_ptw_pte_check: classifies a fetched PTE as leaf/pointer and flags page faults.
module corevx_ptw_pte_check
    import corevx_ptw_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [9:0] ppn0,
    input  logic       level,
    output logic       leaf,
    output logic       pagefault,
    output logic       misaligned
);
    logic invalid;

    assign invalid    = !flags[PTE_V] || (!flags[PTE_R] && flags[PTE_W]);
    assign leaf       = flags[PTE_R] || flags[PTE_X];
    assign misaligned = leaf && level && ppn0 != '0;
    // a pointer found at level 0 has nowhere left to go
    assign pagefault  = invalid || misaligned || (!leaf && !level);
endmodule

// File: rtl/corevx_ptw.sv
// corevx_ptw: Sv32 page table walker reading up to two PTEs over a pipelined read port.
module corevx_ptw
    import corevx_ptw_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_access_bits,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    input  logic        mem_error
);
    state_t      state;
    logic        level;
    logic [19:0] vpn;
    logic        leaf, pagefault, misaligned, ok;
    logic        unused_bits;

    // RSW bits carry no meaning for the walker; misaligned is folded into pagefault
    assign unused_bits = ^{mem_readdata[9:8], misaligned};
    assign ok = !mem_error && !pagefault;

    corevx_ptw_pte_check u_pte_check (
        .flags      (mem_readdata[3:0]),
        .ppn0       (mem_readdata[PPN1_LSB-1:PPN0_LSB]),
        .level      (level),
        .leaf       (leaf),
        .pagefault  (pagefault),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= IDLE;
            level                    <= 1'b1;
            vpn                      <= '0;
            mem_read                 <= 1'b0;
            mem_address              <= '0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_access_bits      <= '0;
        end else begin
            case (state)
                IDLE: if (resolve_request) begin
                    vpn         <= resolve_virtual_address;
                    level       <= 1'b1;
                    mem_read    <= 1'b1;
                    mem_address <= pte_addr(satp_ppn, resolve_virtual_address[19:10]);
                    state       <= READ;
                end
                READ: if (!mem_waitrequest) begin
                    mem_read <= 1'b0;
                    state    <= WAIT_DATA;
                end
                WAIT_DATA: if (mem_readdatavalid) begin
                    if (ok && !leaf) begin
                        level       <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= pte_addr(mem_readdata[31:PPN0_LSB], vpn[9:0]);
                        state       <= READ;
                    end else begin
                        resolve_done             <= 1'b1;
                        resolve_accessfault      <= mem_error;
                        resolve_pagefault        <= !mem_error && pagefault;
                        resolve_physical_address <= !ok ? '0 : level ? {mem_readdata[31:PPN1_LSB], vpn[9:0]}
                                                                     : mem_readdata[31:PPN0_LSB];
                        resolve_access_bits      <= ok ? mem_readdata[PTE_D:PTE_V] : '0;
                        state                    <= DONE;
                    end
                end
                default: begin
                    resolve_done <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_corevx_ptw.sv
// tb_corevx_ptw: randomized and directed checks of the Sv32 walker against a behavioural walk model.
module tb_corevx_ptw;
    logic        clk, rst_n;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_done, resolve_pagefault, resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic        mem_read;
    logic [33:0] mem_address;
    logic        mem_waitrequest, mem_readdatavalid, mem_error;
    logic [31:0] mem_readdata;

    typedef struct packed {
        logic        pf;
        logic        af;
        logic [21:0] phys;
        logic [7:0]  acc;
    } res_t;

    logic [31:0] pmem [logic [33:0]];
    bit          perr [logic [33:0]];
    logic [33:0] seen_addr[$];
    logic [33:0] exp_addr[$];
    res_t        got[$];
    int          done_cnt, first_done, checks, errors;
    bit          stable_bad;

    corevx_ptw dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .mem_read                 (mem_read),
        .mem_address              (mem_address),
        .mem_waitrequest          (mem_waitrequest),
        .mem_readdatavalid        (mem_readdatavalid),
        .mem_readdata             (mem_readdata),
        .mem_error                (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [33:0] a);
        return pmem.exists(a) ? pmem[a] : 32'h0;
    endfunction

    function automatic bit is_err(input logic [33:0] a);
        return perr.exists(a) && perr[a];
    endfunction

    // Walk defined directly from the Sv32 rules: byte addresses as ppn*4096 + index*4
    function automatic res_t model(input logic [21:0] satp, input logic [19:0] va);
        logic [33:0] a;
        logic [31:0] pte;
        res_t r;
        r = '0;
        exp_addr.delete();
        a = {12'b0, satp} * 34'd4096 + {24'b0, va[19:10]} * 34'd4;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            exp_addr.push_back(a);
            pte = rd(a);
            if (is_err(a)) begin r.af = 1'b1; return r; end
            if (!pte[0] || (!pte[1] && pte[2])) begin r.pf = 1'b1; return r; end
            if (pte[1] || pte[3]) begin
                if (lvl == 1 && pte[19:10] != 10'd0) begin r.pf = 1'b1; return r; end
                r.phys = (lvl == 1) ? 22'(int'(pte[31:20]) * 1024 + int'(va[9:0])) : pte[31:10];
                r.acc  = pte[7:0];
                return r;
            end
            if (lvl == 0) begin r.pf = 1'b1; return r; end
            a = {12'b0, pte[31:10]} * 34'd4096 + {24'b0, va[9:0]} * 34'd4;
        end
        return r;
    endfunction

    // Starts a walk and acts as the memory for up to ~120 cycles; cycle 1 is the one after the accepting edge
    task automatic run(input logic [21:0] satp, input logic [19:0] va, input int stall,
                       input bit hold, input int want, input bit noise);
        int st, post;
        bit pending, in_read, pend_err;
        logic [31:0] pend_data;
        seen_addr.delete(); got.delete();
        done_cnt = 0; first_done = -1; stable_bad = 0;
        pending = 0; in_read = 0; st = 0; post = 0; pend_err = 0; pend_data = '0;
        @(negedge clk);
        resolve_request = 1'b1; resolve_virtual_address = va; satp_ppn = satp;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
        for (int c = 1; c < 120 && post < 5; c++) begin
            @(negedge clk);
            if (resolve_done) begin
                done_cnt++;
                got.push_back({resolve_pagefault, resolve_accessfault, resolve_physical_address, resolve_access_bits});
                if (first_done < 0) first_done = c;
            end
            if (done_cnt >= want) post++;
            if (hold) resolve_request = done_cnt < want;
            else resolve_request = noise && (done_cnt == 0 || resolve_done) && $urandom_range(0, 1) == 1;
            if (noise) begin
                resolve_virtual_address = 20'($urandom);
                satp_ppn = 22'($urandom);
            end
            mem_readdatavalid = pending || (noise && $urandom_range(0, 3) == 0);
            mem_readdata = pending ? pend_data : $urandom;
            mem_error = pending ? pend_err : 1'($urandom);
            pending = 0;
            if (mem_read) begin
                if (!in_read) begin
                    seen_addr.push_back(mem_address);
                    in_read = 1; st = stall;
                end else if (mem_address !== seen_addr[$]) stable_bad = 1;
                mem_waitrequest = st > 0;
                if (st > 0) st--;
                else begin
                    in_read = 0; pending = 1;
                    pend_data = rd(mem_address); pend_err = is_err(mem_address);
                end
            end else begin
                if (in_read) stable_bad = 1;
                mem_waitrequest = noise && $urandom_range(0, 1) == 1;
            end
        end
        resolve_request = 1'b0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0; mem_error = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; resolve_request = 1'b0; resolve_virtual_address = '0; satp_ppn = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0; mem_error = 1'b0;
        #1;
        checks++;
        if ({resolve_done, resolve_pagefault, resolve_accessfault, resolve_physical_address,
             resolve_access_bits, mem_read, mem_address} !== 68'd0) begin
            errors++; $display("FAIL reset_outputs got done=%b mem_read=%b addr=%h want all 0",
                                resolve_done, mem_read, mem_address);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || resolve_done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got mem_read=%b done=%b want 0 0", mem_read, resolve_done);
        end
    endtask

    task automatic test_two_level();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h00800001;
        pmem[34'h2000554] = 32'h0003D4CF;
        run(22'h1000, 20'h40155, 0, 0, 1, 0);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL two_level_dones got %0d want 1", done_cnt); end
        checks++; if (seen_addr.size() !== 2) begin errors++; $display("FAIL two_level_reads got %0d want 2", seen_addr.size()); end
        checks++; if (seen_addr[0] !== 34'h1000400) begin errors++; $display("FAIL two_level_addr1 got %h want 1000400", seen_addr[0]); end
        checks++; if (seen_addr[1] !== 34'h2000554) begin errors++; $display("FAIL two_level_addr0 got %h want 2000554", seen_addr[1]); end
        checks++; if (got[0] !== res_t'({1'b0, 1'b0, 22'hF5, 8'hCF})) begin errors++; $display("FAIL two_level_result got %h want %h", got[0], res_t'({1'b0, 1'b0, 22'hF5, 8'hCF})); end
        checks++; if (first_done !== 5) begin errors++; $display("FAIL two_level_latency got cycle %0d want 5", first_done); end
    endtask

    task automatic test_superpage();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h123000CF;
        run(22'h1000, 20'h40155, 0, 0, 1, 0);
        checks++; if (seen_addr.size() !== 1) begin errors++; $display("FAIL super_reads got %0d want 1", seen_addr.size()); end
        checks++; if (got[0] !== res_t'({1'b0, 1'b0, 22'h48D55, 8'hCF})) begin errors++; $display("FAIL super_result got %h want %h", got[0], res_t'({1'b0, 1'b0, 22'h48D55, 8'hCF})); end
        checks++; if (first_done !== 3) begin errors++; $display("FAIL super_latency got cycle %0d want 3", first_done); end
    endtask

    task automatic test_pagefaults();
        logic [31:0] ptes [3];
        ptes[0] = 32'h0; ptes[1] = 32'h00000005; ptes[2] = 32'h123004CF;
        for (int i = 0; i < 3; i++) begin
            pmem.delete(); perr.delete();
            pmem[34'h1000400] = ptes[i];
            run(22'h1000, 20'h40155, 0, 0, 1, 0);
            checks++;
            if (done_cnt !== 1 || seen_addr.size() !== 1 || got[0] !== res_t'({1'b1, 1'b0, 22'h0, 8'h0})) begin
                errors++; $display("FAIL pagefault_l1 pte=%h got dones=%0d reads=%0d res=%h want 1 1 %h",
                                    ptes[i], done_cnt, seen_addr.size(), got[0], res_t'({1'b1, 1'b0, 22'h0, 8'h0}));
            end
        end
    endtask

    task automatic test_second_faults();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h00800001;
        pmem[34'h2000554] = 32'h00800001;
        run(22'h1000, 20'h40155, 0, 0, 1, 0);
        checks++;
        if (seen_addr.size() !== 2 || got[0] !== res_t'({1'b1, 1'b0, 22'h0, 8'h0})) begin
            errors++; $display("FAIL pointer_at_l0 got reads=%0d res=%h want 2 %h", seen_addr.size(), got[0], res_t'({1'b1, 1'b0, 22'h0, 8'h0}));
        end
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h123000CF;
        perr[34'h1000400] = 1'b1;
        run(22'h1000, 20'h40155, 0, 0, 1, 0);
        checks++;
        if (seen_addr.size() !== 1 || got[0] !== res_t'({1'b0, 1'b1, 22'h0, 8'h0})) begin
            errors++; $display("FAIL access_fault got reads=%0d res=%h want 1 %h", seen_addr.size(), got[0], res_t'({1'b0, 1'b1, 22'h0, 8'h0}));
        end
    endtask

    task automatic test_handshake();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h00800001;
        pmem[34'h2000554] = 32'h0003D4CF;
        run(22'h1000, 20'h40155, 3, 0, 1, 1);
        checks++; if (stable_bad !== 1'b0) begin errors++; $display("FAIL stall_stability got unstable=%b want 0", stable_bad); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_request_dones got %0d want 1", done_cnt); end
        checks++;
        if (seen_addr.size() !== 2 || seen_addr[0] !== 34'h1000400 || seen_addr[1] !== 34'h2000554) begin
            errors++; $display("FAIL stall_addresses got n=%0d %h %h want 2 1000400 2000554", seen_addr.size(), seen_addr[0], seen_addr[1]);
        end
        checks++; if (got[0] !== res_t'({1'b0, 1'b0, 22'hF5, 8'hCF})) begin errors++; $display("FAIL stall_result got %h want %h", got[0], res_t'({1'b0, 1'b0, 22'hF5, 8'hCF})); end
    endtask

    task automatic test_reset_midwalk();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h00800001;
        pmem[34'h2000554] = 32'h0003D4CF;
        @(negedge clk);
        resolve_request = 1'b1; resolve_virtual_address = 20'h40155; satp_ppn = 22'h1000; mem_waitrequest = 1'b0;
        @(negedge clk);
        resolve_request = 1'b0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL midwalk_read got %b want 1", mem_read); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resolve_done, resolve_pagefault, resolve_accessfault, resolve_physical_address,
             resolve_access_bits, mem_read, mem_address} !== 68'd0) begin
            errors++; $display("FAIL midwalk_reset_outputs got done=%b mem_read=%b addr=%h want all 0", resolve_done, mem_read, mem_address);
        end
        mem_readdatavalid = 1'b1; mem_readdata = 32'h123000CF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (resolve_done !== 1'b0 || mem_read !== 1'b0) begin
                errors++; $display("FAIL midwalk_no_done got done=%b mem_read=%b want 0 0", resolve_done, mem_read);
            end
        end
        mem_readdatavalid = 1'b0;
        run(22'h1000, 20'h40155, 0, 0, 1, 0);
        checks++;
        if (done_cnt !== 1 || got[0] !== res_t'({1'b0, 1'b0, 22'hF5, 8'hCF})) begin
            errors++; $display("FAIL walk_after_reset got dones=%0d res=%h want 1 %h", done_cnt, got[0], res_t'({1'b0, 1'b0, 22'hF5, 8'hCF}));
        end
    endtask

    task automatic test_back_to_back();
        pmem.delete(); perr.delete();
        pmem[34'h1000400] = 32'h123000CF;
        run(22'h1000, 20'h40155, 0, 1, 2, 0);
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_dones got %0d want 2", done_cnt); end
        checks++; if (seen_addr.size() !== 2) begin errors++; $display("FAIL b2b_reads got %0d want 2", seen_addr.size()); end
        checks++;
        if (got[0] !== res_t'({1'b0, 1'b0, 22'h48D55, 8'hCF}) || got[1] !== res_t'({1'b0, 1'b0, 22'h48D55, 8'hCF})) begin
            errors++; $display("FAIL b2b_results got %h %h want %h", got[0], got[1], res_t'({1'b0, 1'b0, 22'h48D55, 8'hCF}));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [21:0] satp;
            logic [19:0] va;
            logic [31:0] p1, p0;
            logic [33:0] a1, a0;
            res_t exp;
            int k;
            bit addr_ok;
            satp = 22'($urandom); va = 20'($urandom);
            p1 = $urandom; p0 = $urandom;
            k = $urandom_range(0, 3);
            if (k == 0) p1[3:0] = 4'b0001;
            else if (k == 1) begin p1[19:10] = '0; p1[1:0] = 2'b11; end
            if ($urandom_range(0, 1) == 1) p0[1:0] = 2'b11;
            pmem.delete(); perr.delete();
            a1 = {12'b0, satp} * 34'd4096 + {24'b0, va[19:10]} * 34'd4;
            a0 = {12'b0, p1[31:10]} * 34'd4096 + {24'b0, va[9:0]} * 34'd4;
            pmem[a1] = p1; pmem[a0] = p0;
            if ($urandom_range(0, 7) == 0) perr[a1] = 1'b1;
            if ($urandom_range(0, 7) == 0) perr[a0] = 1'b1;
            exp = model(satp, va);
            run(satp, va, $urandom_range(0, 2), 0, 1, n[0]);
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_dones iter=%0d got %0d want 1", n, done_cnt); end
            checks++; if (got[0] !== exp) begin errors++; $display("FAIL rand_result iter=%0d got %h want %h", n, got[0], exp); end
            addr_ok = seen_addr.size() == exp_addr.size();
            for (int i = 0; i < exp_addr.size() && addr_ok; i++) addr_ok = seen_addr[i] === exp_addr[i];
            checks++;
            if (!addr_ok) begin
                errors++; $display("FAIL rand_addresses iter=%0d got n=%0d first=%h want n=%0d first=%h",
                                    n, seen_addr.size(), seen_addr[0], exp_addr.size(), exp_addr[0]);
            end
            checks++; if (stable_bad !== 1'b0) begin errors++; $display("FAIL rand_stability iter=%0d got unstable=%b want 0", n, stable_bad); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_two_level();
        test_superpage();
        test_pagefaults();
        test_second_faults();
        test_handshake();
        test_reset_midwalk();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
